// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: runs a W = 4*NIBBLES bit operation through a shared
// 4-bit ALU slice. It does one nibble per cycle, starting with the LSB nibble,
// and chains the carry through an internal register.
//
// Ports
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake; req_ready is 1 only in IDLE
//   req_op, req_a, req_b    opcode and operands, latched when the request is accepted
//   alu_a/b/cin/binv/op     drive to the ALU slice for the current pass (0 when idle)
//   alu_less                tied 0; SLT is resolved here, not in the slice
//   alu_result, alu_cout    combinational return from the ALU slice
//   rsp_valid/rsp_ready     response handshake
//   rsp_result/cout/ovf/err registered response, held until the handshake
module alu_nibble_sequencer #(
   parameter int unsigned NIBBLES = 2
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [2:0]             req_op,
   input  logic [4*NIBBLES-1:0]   req_a,
   input  logic [4*NIBBLES-1:0]   req_b,
   output logic [3:0]             alu_a,
   output logic [3:0]             alu_b,
   output logic                   alu_cin,
   output logic                   alu_binv,
   output logic [2:0]             alu_op,
   output logic                   alu_less,
   input  logic [3:0]             alu_result,
   input  logic                   alu_cout,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [4*NIBBLES-1:0]   rsp_result,
   output logic                   rsp_cout,
   output logic                   rsp_ovf,
   output logic                   rsp_err
);

   localparam int unsigned W    = 4 * NIBBLES;
   localparam int unsigned IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [2:0]      op_q, op_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    acc_q, acc_d;
   logic            carry_q, carry_d;

   logic            req_ready_d;
   logic [3:0]      alu_a_d, alu_b_d;
   logic            alu_cin_d, alu_binv_d;
   logic [2:0]      alu_op_d;
   logic            rsp_valid_d, rsp_cout_d, rsp_ovf_d, rsp_err_d;
   logic [W-1:0]    rsp_result_d;

   // Scratch values for the final pass.
   logic [W-1:0]    acc_nxt;
   logic            b_msb_eff;
   logic            ovf_c;
   logic            is_sub_like;

   assign alu_less = 1'b0;

   // Returns nibble k of v.
   function automatic logic [3:0] nibble(input logic [W-1:0] v, input logic [IDXW-1:0] k);
      logic [3:0] r;
      r = 4'h0;
      for (int i = 0; i < int'(NIBBLES); i++) begin
         if (k == IDXW'(i)) r = v[4*i +: 4];
      end
      return r;
   endfunction

   function automatic logic op_legal(input logic [2:0] op);
      return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
             (op == OP_SUB) || (op == OP_SLT);
   endfunction

   // The slice only knows AND, OR and ADD. Subtraction comes from the slice inverting B.
   function automatic logic [2:0] slice_op(input logic [2:0] op);
      logic [2:0] r;
      case (op)
         OP_AND:  r = 3'b000;
         OP_OR:   r = 3'b001;
         default: r = 3'b010;
      endcase
      return r;
   endfunction

   // State and datapath registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         op_q       <= 3'b000;
         a_q        <= '0;
         b_q        <= '0;
         acc_q      <= '0;
         carry_q    <= 1'b0;
         req_ready  <= 1'b1;
         alu_a      <= 4'h0;
         alu_b      <= 4'h0;
         alu_cin    <= 1'b0;
         alu_binv   <= 1'b0;
         alu_op     <= 3'b000;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_cout   <= 1'b0;
         rsp_ovf    <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         acc_q      <= acc_d;
         carry_q    <= carry_d;
         req_ready  <= req_ready_d;
         alu_a      <= alu_a_d;
         alu_b      <= alu_b_d;
         alu_cin    <= alu_cin_d;
         alu_binv   <= alu_binv_d;
         alu_op     <= alu_op_d;
         rsp_valid  <= rsp_valid_d;
         rsp_result <= rsp_result_d;
         rsp_cout   <= rsp_cout_d;
         rsp_ovf    <= rsp_ovf_d;
         rsp_err    <= rsp_err_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      acc_d        = acc_q;
      carry_d      = carry_q;
      req_ready_d  = req_ready;
      alu_a_d      = alu_a;
      alu_b_d      = alu_b;
      alu_cin_d    = alu_cin;
      alu_binv_d   = alu_binv;
      alu_op_d     = alu_op;
      rsp_valid_d  = rsp_valid;
      rsp_result_d = rsp_result;
      rsp_cout_d   = rsp_cout;
      rsp_ovf_d    = rsp_ovf;
      rsp_err_d    = rsp_err;

      acc_nxt      = acc_q;
      for (int i = 0; i < int'(NIBBLES); i++) begin
         if (idx_q == IDXW'(i)) acc_nxt[4*i +: 4] = alu_result;
      end
      // Overflow is judged on the MSB of the current pass. B is inverted there for SUB/SLT.
      b_msb_eff    = alu_b[3] ^ alu_binv;
      ovf_c        = (alu_a[3] == b_msb_eff) && (alu_result[3] != alu_a[3]);
      is_sub_like  = (req_op == OP_SUB) || (req_op == OP_SLT);

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               op_d         = req_op;
               a_d          = req_a;
               b_d          = req_b;
               idx_d        = '0;
               acc_d        = '0;
               rsp_result_d = '0;
               rsp_cout_d   = 1'b0;
               rsp_ovf_d    = 1'b0;
               rsp_err_d    = 1'b0;
               req_ready_d  = 1'b0;
               if (op_legal(req_op)) begin
                  state_d    = RUN;
                  carry_d    = is_sub_like;
                  alu_a_d    = nibble(req_a, '0);
                  alu_b_d    = nibble(req_b, '0);
                  alu_cin_d  = is_sub_like;
                  alu_binv_d = is_sub_like;
                  alu_op_d   = slice_op(req_op);
               end else begin
                  state_d     = DONE;
                  carry_d     = 1'b0;
                  rsp_err_d   = 1'b1;
                  rsp_valid_d = 1'b1;
               end
            end
         end

         RUN: begin
            acc_d   = acc_nxt;
            carry_d = alu_cout;
            idx_d   = idx_q + IDXW'(1);
            if (idx_q == IDXW'(NIBBLES - 1)) begin
               state_d     = DONE;
               rsp_valid_d = 1'b1;
               alu_a_d     = 4'h0;
               alu_b_d     = 4'h0;
               alu_cin_d   = 1'b0;
               alu_binv_d  = 1'b0;
               alu_op_d    = 3'b000;
               case (op_q)
                  OP_ADD, OP_SUB: begin
                     rsp_result_d = acc_nxt;
                     rsp_cout_d   = alu_cout;
                     rsp_ovf_d    = ovf_c;
                  end
                  // Signed less-than is the sign of the difference, corrected for overflow.
                  OP_SLT: rsp_result_d = W'(alu_result[3] ^ ovf_c);
                  default: rsp_result_d = acc_nxt;
               endcase
            end else begin
               alu_a_d   = nibble(a_q, idx_q + IDXW'(1));
               alu_b_d   = nibble(b_q, idx_q + IDXW'(1));
               alu_cin_d = alu_cout;
            end
         end

         DONE: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
            end
         end

         default: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
            req_ready_d = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Randomized self-checking bench for alu_nibble_sequencer with NIBBLES=2.
// The bench includes a behavioural 4-bit ALU slice and a word-level reference model.
module tb_alu_nibble_sequencer;

   localparam int unsigned NIB = 2;
   localparam int unsigned W   = 4 * NIB;

   logic           clock = 1'b0;
   logic           reset_n;
   logic           req_valid;
   logic           req_ready;
   logic [2:0]     req_op;
   logic [W-1:0]   req_a, req_b;
   logic [3:0]     alu_a, alu_b;
   logic           alu_cin, alu_binv;
   logic [2:0]     alu_op;
   logic           alu_less;
   logic [3:0]     alu_result;
   logic           alu_cout;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [W-1:0]   rsp_result;
   logic           rsp_cout, rsp_ovf, rsp_err;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   alu_nibble_sequencer #(.NIBBLES(NIB)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_cin    (alu_cin),
      .alu_binv   (alu_binv),
      .alu_op     (alu_op),
      .alu_less   (alu_less),
      .alu_result (alu_result),
      .alu_cout   (alu_cout),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_cout   (rsp_cout),
      .rsp_ovf    (rsp_ovf),
      .rsp_err    (rsp_err)
   );

   // Behavioural 4-bit ALU slice
   logic [3:0] bx;
   logic [4:0] sum5;
   assign bx   = alu_b ^ {4{alu_binv}};
   assign sum5 = {1'b0, alu_a} + {1'b0, bx} + {4'b0, alu_cin};
   always_comb begin
      alu_result = sum5[3:0];
      alu_cout   = 1'b0;
      case (alu_op[1:0])
         2'b00:   alu_result = alu_a & bx;
         2'b01:   alu_result = alu_a | bx;
         default: begin
            alu_result = sum5[3:0];
            alu_cout   = sum5[4];
         end
      endcase
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int sval(input logic [W-1:0] v);
      return v[W-1] ? int'(v) - (1 << W) : int'(v);
   endfunction

   // Word-level reference, using plain integer arithmetic
   task automatic ref_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] r, output logic c, output logic o,
                            output logic e);
      int u, s;
      int maxs, mins;
      maxs = (1 << (W - 1)) - 1;
      mins = -(1 << (W - 1));
      r = '0; c = 1'b0; o = 1'b0; e = 1'b0;
      case (op)
         3'b000: r = a & b;
         3'b001: r = a | b;
         3'b010: begin
            u = int'(a) + int'(b);
            r = W'(u);
            c = (u >= (1 << W));
            s = sval(a) + sval(b);
            o = (s > maxs) || (s < mins);
         end
         3'b110: begin
            u = int'(a) + ((1 << W) - 1 - int'(b)) + 1;
            r = W'(u);
            c = (u >= (1 << W));
            s = sval(a) - sval(b);
            o = (s > maxs) || (s < mins);
         end
         3'b111: r = (sval(a) < sval(b)) ? W'(1) : W'(0);
         default: e = 1'b1;
      endcase
   endtask

   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold);
      logic [W-1:0] er;
      logic         ec, eo, ee;
      logic         subl;
      int           edges;
      int           eop;
      ref_model(op, a, b, er, ec, eo, ee);
      subl = (op == 3'b110) || (op == 3'b111);
      eop  = (op == 3'b000) ? 0 : (op == 3'b001) ? 1 : 2;

      @(negedge clock);
      check("req_ready_idle", 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      req_op    = 3'($urandom);
      req_a     = W'($urandom);
      req_b     = W'($urandom);
      edges     = 1;
      check("req_ready_busy", 64'(req_ready), 64'd0);
      if (!ee) begin
         check("alu_a_first", 64'(alu_a), 64'(a[3:0]));
         check("alu_b_first", 64'(alu_b), 64'(b[3:0]));
         check("alu_cin_first", 64'(alu_cin), 64'(subl));
         check("alu_binv_first", 64'(alu_binv), 64'(subl));
         check("alu_op_first", 64'(alu_op), 64'(eop));
         check("alu_less", 64'(alu_less), 64'd0);
      end
      while (!rsp_valid && edges < 20) begin
         @(posedge clock);
         #1;
         edges++;
      end
      check("latency", 64'(edges), ee ? 64'd1 : 64'(NIB + 1));
      check("rsp_result", 64'(rsp_result), 64'(er));
      check("rsp_cout", 64'(rsp_cout), 64'(ec));
      check("rsp_ovf", 64'(rsp_ovf), 64'(eo));
      check("rsp_err", 64'(rsp_err), 64'(ee));
      check("alu_a_done", 64'({alu_a, alu_b, alu_cin, alu_binv, alu_op}), 64'd0);
      for (int k = 0; k < hold; k++) begin
         @(posedge clock);
         #1;
         check("hold_valid", 64'(rsp_valid), 64'd1);
         check("hold_result", 64'({rsp_result, rsp_cout, rsp_ovf, rsp_err}),
               64'({er, ec, eo, ee}));
         check("hold_ready", 64'(req_ready), 64'd0);
      end
      @(negedge clock);
      rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      rsp_ready = 1'b0;
      check("after_hs_valid", 64'(rsp_valid), 64'd0);
      check("after_hs_ready", 64'(req_ready), 64'd1);
   endtask

   logic [2:0] legal_ops [5];
   logic [2:0] illegal_ops [3];

   initial begin
      legal_ops   = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
      illegal_ops = '{3'b011, 3'b100, 3'b101};
      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_op    = 3'b000;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      #12;
      check("rst_rsp", 64'({rsp_valid, rsp_result, rsp_cout, rsp_ovf, rsp_err}), 64'd0);
      check("rst_alu", 64'({alu_a, alu_b, alu_cin, alu_binv, alu_op}), 64'd0);
      check("rst_ready", 64'(req_ready), 64'd1);
      @(negedge clock);
      reset_n = 1'b1;

      // Directed cases
      run_op(3'b010, 8'h3A, 8'h47, 0);
      run_op(3'b110, 8'h10, 8'h01, 1);
      run_op(3'b111, 8'h80, 8'h01, 0);
      run_op(3'b111, 8'h01, 8'h80, 0);
      run_op(3'b000, 8'hF0, 8'h3C, 2);
      run_op(3'b001, 8'h0F, 8'h30, 0);
      run_op(3'b011, 8'h55, 8'hAA, 3);
      run_op(3'b010, 8'hFF, 8'h01, 0);
      run_op(3'b110, 8'h00, 8'h01, 0);
      run_op(3'b110, 8'h80, 8'h01, 0);

      // Reset in the middle of RUN aborts the operation
      @(negedge clock);
      req_valid = 1'b1;
      req_op    = 3'b010;
      req_a     = 8'hFF;
      req_b     = 8'h01;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrun_rsp", 64'({rsp_valid, rsp_result, rsp_cout, rsp_ovf, rsp_err}), 64'd0);
      check("midrun_alu", 64'({alu_a, alu_b, alu_cin, alu_binv, alu_op}), 64'd0);
      check("midrun_ready", 64'(req_ready), 64'd1);
      @(negedge clock);
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clock);
         #1;
         check("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
      end
      run_op(3'b010, 8'h01, 8'h01, 0);

      // Randomized traffic
      for (int n = 0; n < 80; n++) begin
         int sel;
         logic [2:0] op;
         sel = int'($urandom_range(0, 9));
         if (sel < 8) op = legal_ops[sel % 5];
         else         op = illegal_ops[$urandom_range(0, 2)];
         run_op(op, W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
